// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM controller: FSM state encoding, SRAM bus
// widths and the width of the per-phase wait counter.
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_AW = 18;  // halfword address width
    localparam int SRAM_DW = 16;  // SRAM data bus width
    localparam int WAIT_CW = 4;   // wait counter width (WAIT_CYCLES up to 15)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
// Counts the cycles spent in one halfword phase. 'load' restarts the count at
// zero (phase entry), 'enable' advances it, and 'tc' flags the final cycle of
// a WAIT_CYCLES-long phase.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   load   - clear the count (takes priority over enable)
//   enable - advance the count by one
//   tc     - terminal count: current cycle is the last of the phase
// -----------------------------------------------------------------------------
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    logic [WAIT_CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WAIT_CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Bridges a 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM by
// splitting each word into a low halfword phase and a high halfword phase,
// each held for WAIT_CYCLES clocks. The pipeline is frozen (ready=0) while a
// transfer is in flight.
//
// Optional feature: define SRAM_ADDR_CHECK_EN to reject addresses below
// BASE_ADDR or beyond the SRAM window; such requests complete immediately
// with addr_err=1 and no SRAM activity. Without it addr_err is always 0.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   wr_en, rd_en      - store / load request, held until ready
//   address           - word-aligned byte address
//   writeData         - store data
//   readData          - load data, valid while ready=1 in DONE
//   ready             - 0 freezes the pipeline
//   SRAM_ADDR         - halfword address to SRAM
//   SRAM_DQ_out/_oe   - write data and its output enable
//   SRAM_DQ_in        - read data from SRAM
//   SRAM_WE_N         - active-low write strobe
//   addr_err          - one-cycle out-of-range flag
// -----------------------------------------------------------------------------
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [SRAM_DW-1:0] SRAM_DQ_in,
    output logic               SRAM_WE_N,
    output logic               addr_err
);

    state_t             state, next_state;
    logic [SRAM_AW-2:0] word_q;     // SRAM word index of the latched request
    logic [31:0]        wdata_q;
    logic               write_q;
    logic               req, range_err;
    logic               cnt_load, cnt_en, cnt_tc;
    logic [31:0]        offset;
    logic               unused_offset_bits;

    assign req    = wr_en | rd_en;
    assign offset = address - BASE_ADDR;

    // Alignment bits and (without the range check) the bits above the SRAM
    // window carry no information for the transfer.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
    logic err_q;
    assign range_err = (address < BASE_ADDR) || (offset[31:19] != '0);
    assign addr_err  = (state == ST_DONE) && err_q;
`else
    assign range_err = 1'b0;
    assign addr_err  = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .enable(cnt_en),
        .tc    (cnt_tc)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        next_state  = state;
        ready       = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_DQ_out = '0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;

        case (state)
            ST_IDLE: begin
                ready = ~req;
                if (req) begin
                    cnt_load   = 1'b1;
                    next_state = range_err ? ST_DONE : ST_LOW;
                end
            end
            ST_LOW: begin
                cnt_en    = 1'b1;
                SRAM_ADDR = {word_q, 1'b0};
                if (write_q) begin
                    SRAM_WE_N   = 1'b0;
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_DQ_out = wdata_q[15:0];
                end
                if (cnt_tc) begin
                    cnt_load   = 1'b1;  // restart the count for the high phase
                    next_state = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_en    = 1'b1;
                SRAM_ADDR = {word_q, 1'b1};
                if (write_q) begin
                    SRAM_WE_N   = 1'b0;
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_DQ_out = wdata_q[31:16];
                end
                if (cnt_tc) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                ready      = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: only control and data-holding registers are reset; the SRAM bus
    // outputs are decoded from state, so they fall to their idle values
    // together with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            readData <= '0;
`ifdef SRAM_ADDR_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req) begin
                word_q  <= offset[18:2];
                wdata_q <= writeData;
                write_q <= wr_en;  // simultaneous wr_en/rd_en is a write
`ifdef SRAM_ADDR_CHECK_EN
                err_q   <= range_err;
`endif
            end
            // Reads capture each halfword on the last cycle of its phase,
            // giving the SRAM the full WAIT_CYCLES to settle.
            if (state == ST_LOW && !write_q && cnt_tc) begin
                readData[15:0] <= SRAM_DQ_in;
            end
            if (state == ST_HIGH && !write_q && cnt_tc) begin
                readData[31:16] <= SRAM_DQ_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Directed bench for sram_controller. Instance 'a' (WAIT_CYCLES=1) talks to a
// small behavioural SRAM; instance 'b' (WAIT_CYCLES=3) has its DQ input driven
// cycle by cycle to show exactly when data is captured.
// -----------------------------------------------------------------------------
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance a: WAIT_CYCLES = 1
    logic        wr_a = 0, rd_a = 0;
    logic [31:0] addr_a = 0, wd_a = 0;
    logic [31:0] rdata_a;
    logic        ready_a, oe_a, we_n_a, err_a;
    logic [17:0] sram_addr_a;
    logic [15:0] dq_out_a, dq_in_a;

    // Instance b: WAIT_CYCLES = 3
    logic        rd_b = 0;
    logic [31:0] addr_b = 0;
    logic [31:0] rdata_b;
    logic        ready_b, oe_b, we_n_b, err_b;
    logic [17:0] sram_addr_b;
    logic [15:0] dq_out_b;
    logic [15:0] dq_in_b = 0;

    sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a),
        .address(addr_a), .writeData(wd_a), .readData(rdata_a), .ready(ready_a),
        .SRAM_ADDR(sram_addr_a), .SRAM_DQ_out(dq_out_a), .SRAM_DQ_oe(oe_a),
        .SRAM_DQ_in(dq_in_a), .SRAM_WE_N(we_n_a), .addr_err(err_a)
    );

    sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) dut_b (
        .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd_b),
        .address(addr_b), .writeData(32'h0), .readData(rdata_b), .ready(ready_b),
        .SRAM_ADDR(sram_addr_b), .SRAM_DQ_out(dq_out_b), .SRAM_DQ_oe(oe_b),
        .SRAM_DQ_in(dq_in_b), .SRAM_WE_N(we_n_b), .addr_err(err_b)
    );

    // Behavioural SRAM for instance a: 16 halfwords, low address bits only.
    logic [15:0] mem_a [16];
    assign dq_in_a = mem_a[sram_addr_a[3:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= 16'h0;
            mem_a[0] <= 16'h1357;
            mem_a[1] <= 16'h2468;
        end else if (!we_n_a) begin
            mem_a[sram_addr_a[3:0]] <= dq_out_a;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wr_a = w; rd_a = r; addr_a = a; wd_a = d;
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        check("rst_ready",   {31'b0, ready_a}, 32'd1);
        check("rst_rdata",   rdata_a, 32'h0);
        check("rst_we_n",    {31'b0, we_n_a}, 32'd1);
        check("rst_oe",      {31'b0, oe_a}, 32'd0);
        check("rst_addr",    {14'b0, sram_addr_a}, 32'h0);
        check("rst_dq_out",  {16'b0, dq_out_a}, 32'h0);
        check("rst_addr_err", {31'b0, err_a}, 32'd0);
        rst = 1'b0;

        // ---------------- write 0xDEADBEEF to 1028 ----------------
        req_a(1, 0, 32'd1028, 32'hDEADBEEF);
        check("wr_idle_ready", {31'b0, ready_a}, 32'd0);
        tick();
        check("wr_low_addr",  {14'b0, sram_addr_a}, 32'd2);
        check("wr_low_dq",    {16'b0, dq_out_a}, 32'h0000BEEF);
        check("wr_low_we_n",  {31'b0, we_n_a}, 32'd0);
        check("wr_low_oe",    {31'b0, oe_a}, 32'd1);
        check("wr_low_ready", {31'b0, ready_a}, 32'd0);
        tick();
        check("wr_high_addr", {14'b0, sram_addr_a}, 32'd3);
        check("wr_high_dq",   {16'b0, dq_out_a}, 32'h0000DEAD);
        check("wr_high_we_n", {31'b0, we_n_a}, 32'd0);
        tick();
        check("wr_done_ready", {31'b0, ready_a}, 32'd1);
        check("wr_done_we_n",  {31'b0, we_n_a}, 32'd1);
        check("wr_done_rdata", rdata_a, 32'h0);
        req_a(0, 0, 32'd0, 32'd0);
        tick();
        check("wr_mem_lo", {16'b0, mem_a[2]}, 32'h0000BEEF);
        check("wr_mem_hi", {16'b0, mem_a[3]}, 32'h0000DEAD);
        check("idle_ready", {31'b0, ready_a}, 32'd1);

        // ---------------- read 1028 ----------------
        req_a(0, 1, 32'd1028, 32'd0);
        tick();
        check("rd_low_we_n", {31'b0, we_n_a}, 32'd1);
        check("rd_low_oe",   {31'b0, oe_a}, 32'd0);
        tick(); tick();
        check("rd_done_ready", {31'b0, ready_a}, 32'd1);
        check("rd_done_rdata", rdata_a, 32'hDEADBEEF);
        req_a(0, 0, 32'd0, 32'd0);
        tick();
        check("rd_hold_rdata", rdata_a, 32'hDEADBEEF);
        exp_rd = 32'hDEADBEEF;

        // ---------------- out-of-range address ----------------
        req_a(0, 1, 32'h00100000, 32'd0);
`ifdef SRAM_ADDR_CHECK_EN
        tick();
        check("oor_done_ready", {31'b0, ready_a}, 32'd1);
        check("oor_addr_err",   {31'b0, err_a}, 32'd1);
        check("oor_we_n",       {31'b0, we_n_a}, 32'd1);
        check("oor_oe",         {31'b0, oe_a}, 32'd0);
        check("oor_rdata",      rdata_a, exp_rd);
        req_a(0, 0, 32'd0, 32'd0);
        tick();
        check("oor_err_clear",  {31'b0, err_a}, 32'd0);
`else
        tick();
        check("oor_low_addr",  {14'b0, sram_addr_a}, 32'h0003FE00);
        check("oor_addr_err",  {31'b0, err_a}, 32'd0);
        tick();
        check("oor_high_addr", {14'b0, sram_addr_a}, 32'h0003FE01);
        tick();
        check("oor_done_ready", {31'b0, ready_a}, 32'd1);
        check("oor_rdata",      rdata_a, 32'h24681357);
        exp_rd = 32'h24681357;
        req_a(0, 0, 32'd0, 32'd0);
        tick();
`endif

        // ---------------- back-to-back write then read of 1024 ----------------
        req_a(1, 0, 32'd1024, 32'h12345678);
        tick(); tick(); tick();
        check("b2b_wr_ready", {31'b0, ready_a}, 32'd1);
        check("b2b_wr_rdata", rdata_a, exp_rd);
        req_a(0, 1, 32'd1024, 32'd0);
        tick();
        check("b2b_idle_ready", {31'b0, ready_a}, 32'd0);
        tick();
        check("b2b_rd_low_addr", {14'b0, sram_addr_a}, 32'd0);
        check("b2b_rd_low_we_n", {31'b0, we_n_a}, 32'd1);
        tick();
        check("b2b_rd_high_addr", {14'b0, sram_addr_a}, 32'd1);
        tick();
        check("b2b_rd_ready", {31'b0, ready_a}, 32'd1);
        check("b2b_rd_rdata", rdata_a, 32'h12345678);
        req_a(0, 0, 32'd0, 32'd0);
        tick();

        // ---------------- wr_en and rd_en together: write ----------------
        req_a(1, 1, 32'd1032, 32'hA5A55A5A);
        tick();
        check("both_low_we_n", {31'b0, we_n_a}, 32'd0);
        check("both_low_addr", {14'b0, sram_addr_a}, 32'd4);
        tick(); tick();
        check("both_done_rdata", rdata_a, 32'h12345678);
        req_a(0, 0, 32'd0, 32'd0);
        tick();
        check("both_mem_lo", {16'b0, mem_a[4]}, 32'h00005A5A);
        check("both_mem_hi", {16'b0, mem_a[5]}, 32'h0000A5A5);

        // ---------------- reset during HIGH of a read ----------------
        req_a(0, 1, 32'd1028, 32'd0);
        tick(); tick();
        check("abort_in_high", {14'b0, sram_addr_a}, 32'd3);
        rst = 1'b1;
        tick();
        check("abort_we_n",  {31'b0, we_n_a}, 32'd1);
        check("abort_rdata", rdata_a, 32'h0);
        check("abort_addr",  {14'b0, sram_addr_a}, 32'h0);
        check("abort_ready_req", {31'b0, ready_a}, 32'd0);
        req_a(0, 0, 32'd0, 32'd0);
        check("abort_ready_idle", {31'b0, ready_a}, 32'd1);
        rst = 1'b0;
        tick();

        // ---------------- WAIT_CYCLES=3 read timing ----------------
        begin
            logic [15:0] dq_seq [6];
            dq_seq[0] = 16'h1111; dq_seq[1] = 16'h2222; dq_seq[2] = 16'hBEEF;
            dq_seq[3] = 16'h3333; dq_seq[4] = 16'h4444; dq_seq[5] = 16'hDEAD;
            rd_b = 1'b1; addr_b = 32'd1028;
            for (int i = 1; i <= 6; i++) begin
                tick();
                dq_in_b = dq_seq[i-1];
                check($sformatf("w3_ready_c%0d", i), {31'b0, ready_b}, 32'd0);
                check($sformatf("w3_addr_c%0d", i), {14'b0, sram_addr_b}, (i <= 3) ? 32'd2 : 32'd3);
                if (i == 4) check("w3_rdata_half", rdata_b, 32'h0000BEEF);
            end
            tick();
            check("w3_ready_c7", {31'b0, ready_b}, 32'd1);
            check("w3_rdata",    rdata_b, 32'hDEADBEEF);
            rd_b = 1'b0;
            tick();
            check("w3_idle_ready", {31'b0, ready_b}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
